// File: rtl/arb_pkg.sv
// Shared definitions for the N-way arbiter.
//   ARB_RR / ARB_FIXED : policy selector values for the RR parameter
//   arb_state_e        : arbiter state (no holder / holder present)
//   arb_width()        : index/counter width helper, never narrower than 1 bit
package arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Bits needed to hold values 0..n-1, with a floor of one bit so that
    // degenerate sizes (n=1) still produce a legal vector.
    function automatic int arb_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational masked priority picker.
//   req_i    : request vector
//   mask_i   : requesters excluded from this pick (bit set = excluded)
//   start_i  : index scanned first; the scan wraps from N-1 back to 0
//   onehot_o : one-hot winner, zero when nothing eligible
//   idx_o    : winner index, zero when nothing eligible
//   found_o  : an eligible requester exists
module arb_pick
    import arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = arb_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] start_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    logic [N-1:0] eligible;
    logic [N-1:0] one;

    assign eligible = req_i & ~mask_i;
    assign one      = N'(1);

    // First eligible requester at or after start_i, in circular order.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found_o && eligible[(int'(start_i) + k) % N]) begin
                found_o = 1'b1;
                idx_o   = IW'((int'(start_i) + k) % N);
            end
        end
    end

    assign onehot_o = found_o ? (one << idx_o) : '0;

endmodule

// File: rtl/rr_arbiter.sv
// N-way arbiter with round-robin or fixed-priority policy, grant locking
// while the holder keeps requesting, and a bounded hold time that forces a
// hand-over when others are waiting.
//   i_clk    : clock, rising edge
//   i_rst    : asynchronous active-high reset
//   i_req    : level-sensitive requests, one per requester
//   o_gnt    : registered one-hot grant (or all-zero)
//   o_gnt_id : index of the current holder, 0 when nothing granted
//   o_valid  : any grant asserted
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int RR       = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N-1:0]            i_req,
    output logic [N-1:0]            o_gnt,
    output logic [arb_width(N)-1:0] o_gnt_id,
    output logic                    o_valid
);

    localparam int             IW       = arb_width(N);
    localparam int             CW       = arb_width(MAX_HOLD + 1);
    localparam logic [CW-1:0]  HOLD_LIM = CW'(MAX_HOLD);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);
    localparam bit             LIMITED  = (MAX_HOLD > 0);
    localparam bit             USE_RR   = (RR == ARB_RR);

    arb_state_e     state_q, state_d;
    logic [N-1:0]   gnt_q,   gnt_d;
    logic [IW-1:0]  id_q,    id_d;
    logic [IW-1:0]  ptr_q,   ptr_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic           valid_q, valid_d;

    logic           holder_req;
    logic           others_req;
    logic           hold_full;
    logic           force_ho;
    logic           keep;
    logic [N-1:0]   pick_mask;
    logic [IW-1:0]  pick_start;
    logic [N-1:0]   pick_onehot;
    logic [IW-1:0]  pick_idx;
    logic           pick_found;

    // gnt_q doubles as the holder's one-hot mask; it is zero when idle.
    assign holder_req = |(i_req & gnt_q);
    assign others_req = |(i_req & ~gnt_q);
    assign hold_full  = LIMITED && (cnt_q == HOLD_LIM);
    assign force_ho   = (state_q == BUSY) && holder_req && hold_full && others_req;
    assign keep       = (state_q == BUSY) && holder_req && !force_ho;

    // The holder is only excluded on a forced hand-over; on a release its
    // request bit is already low.
    assign pick_mask  = force_ho ? gnt_q : '0;
    assign pick_start = USE_RR ? ptr_q : '0;

    arb_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req_i    (i_req),
        .mask_i   (pick_mask),
        .start_i  (pick_start),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .found_o  (pick_found)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (keep) begin
            // Alone at the limit: restart the window instead of wrapping.
            if (hold_full) begin
                cnt_d = CNT_ONE;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (pick_found) begin
            state_d = BUSY;
            gnt_d   = pick_onehot;
            id_d    = pick_idx;
            cnt_d   = CNT_ONE;
            if (USE_RR) begin
                ptr_d = (pick_idx == LAST_IDX) ? '0 : pick_idx + IW'(1);
            end
        end else begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
            cnt_d   = '0;
        end
        valid_d = |gnt_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign o_gnt    = gnt_q;
    assign o_gnt_id = id_q;
    assign o_valid  = valid_q;

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Parametrised N-way arbiter: the next generation of the two-port request/grant arbiter. It adds selectable round-robin or fixed-priority policy, grant locking while the holder keeps requesting, and a bounded hold time that forces hand-over to waiting requesters. It sits in front of any shared resource (bus, memory port, FIFO write side) and gives one-hot registered grants plus an encoded grant index.

## Interface
- N, 4, number of requesters; legal range 1..32
- RR, 1, policy: 1 = round-robin, 0 = fixed priority (index 0 highest)
- MAX_HOLD, 8, maximum consecutive grant cycles while others wait; 0 = unlimited
- IW, derived, index width = max(1, clog2(N)); localparam, not overridable
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset; asynchronous, active-high
- i_req  in  N  request per requester, level-sensitive
- o_gnt  out  N  registered grant, one-hot or all-zero
- o_gnt_id  out  IW  index of current holder; 0 when o_valid=0
- o_valid  out  1  any grant asserted (OR of o_gnt)

## Operation
- States: IDLE (no holder), BUSY (holder h).
- Reset: o_gnt=0, o_gnt_id=0, o_valid=0, hold counter=0, RR pointer=0 (index 0 has top priority first), state IDLE. Reset asserted mid-grant clears all outputs immediately.
- IDLE, any i_req set: the winner w is picked at the edge. State goes to BUSY(w), o_gnt[w]=1, and the counter loads 1.
- IDLE, i_req=0: stay IDLE, outputs zero.
- BUSY(h), i_req[h]=1, and either the counter is below MAX_HOLD or no other request is set: keep h and increment the counter. If MAX_HOLD is reached with no competitor, the counter reloads 1.
- BUSY(h), i_req[h]=0: re-arbitrate at the same edge over the current i_req. If there is a winner, grant moves to it with no idle bubble and the counter loads 1. Otherwise go to IDLE.
- BUSY(h), i_req[h]=1, counter==MAX_HOLD (MAX_HOLD>0), and another request is set: forced hand-over. Re-arbitrate with h masked out. The new winner is granted and the counter loads 1.
- Round-robin winner: the first set request scanning upward from the pointer, wrapping N-1 to 0. On every new grant to w, the pointer becomes (w+1) mod N. The pointer does not move while a grant is held.
- Fixed winner: the lowest set index, with h masked on forced hand-over. Preemption does not occur in the middle of a hold, even if a higher-priority request arrives.
- N=1: the single requester is granted whenever i_req[0]=1. Forced hand-over never fires.
- The counter width is clog2(MAX_HOLD+1) and it saturates. No arithmetic wraps.

## Timing
- Latency from request to grant: 1 edge. i_req sampled high at edge k gives o_gnt high after edge k.
- Release: holder drops i_req before edge k, and o_gnt drops or moves after edge k.
- o_gnt, o_gnt_id and o_valid are all registered and change only on i_clk or i_rst. There is no combinational path from input to output.
- Under forced hand-over, a holder sees exactly MAX_HOLD consecutive grant cycles.
- A requester that drops i_req while never granted loses nothing. No pending state is stored.

## Structure
- Shared package arb_pkg: policy constants ARB_RR=1 and ARB_FIXED=0, a state enum {IDLE, BUSY}, and a clog2-based width helper.
- Sub-module arb_pick: combinational masked priority picker. Inputs are req[N], mask[N] and start index[IW]. Outputs are one-hot, index and found. It is instantiated once. Fixed mode ties start to 0.
- Top level holds the state register, holder index, RR pointer and hold counter.

## Test plan
- Reset, then single request with N=4, RR=1, MAX_HOLD=4. i_req=0001 → o_gnt=0001, o_gnt_id=0, o_valid=1 one edge later; outputs were zero during reset.
- Round-robin fairness. i_req=1111, and each holder drops its request for one cycle after each grant. → Grant order is 0,1,2,3,0, with no idle cycle between grants.
- Hold limit. i_req=0011 held constant, MAX_HOLD=4. → Grant alternates between 0 and 1 every 4 cycles. With i_req=0001 alone, the grant stays on 0 indefinitely.
- Fixed priority, RR=0. Holder 2, then i_req becomes 0101. → The grant stays on 2 until release or MAX_HOLD, then moves to 0. After release with i_req=0110, the grant goes to 1.
- Asynchronous reset mid-grant. Assert i_rst between edges while o_gnt=0100. → All outputs are 0 immediately. After release with i_req=1111, the grant goes to 0 (pointer reset).
- Wrap and N=1. With holder 3 in RR mode and i_req=1001 after release, the grant goes to 0. With N=1 and i_req toggling, o_gnt follows i_req delayed by 1 edge.
